// File: rtl/branch_pkg.sv
// Shared definitions for the fetch-stage branch predictor: resolver result
// codes, 2-bit counter encodings and the BTB entry layout.
// The entry struct is sized from BP_WIDTH / BP_ENTRIES; a top-level build
// with a different PC width or table depth must change these constants too.
package branch_pkg;

    localparam int BP_WIDTH   = 32;
    localparam int BP_ENTRIES = 16;
    localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
    localparam int BP_TAG_W   = BP_WIDTH - BP_IDX_W - 2;

    // Result codes returned by the execute-stage branch resolver
    localparam logic [1:0] RES_WRONG_TARGET = 2'b00;
    localparam logic [1:0] RES_CORRECT      = 2'b01;
    localparam logic [1:0] RES_RET_PC4      = 2'b10;
    localparam logic [1:0] RES_TAKE_ALU     = 2'b11;

    // Saturating counter states; MSB is the taken prediction
    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;
    localparam logic [1:0] CTR_RESET     = CTR_WEAK_NT;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_WIDTH-1:0] target;
        logic [1:0]          ctr;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing signal bundle of the branch predictor.
// Handshake: there is no ready; the predictor accepts every cycle. The
// lookup (PC_F -> Predicted/PC_Pre) is always live. Update_Valid is the sole
// valid: when it is 1, PC_E/PC_ALU/Execute_E/Result describe one resolved
// branch consumed at the next rising edge, and Flush/PC_Redirect respond in
// the same cycle. When it is 0 the update fields are don't-care.
interface branch_predictor_if #(
    parameter int WIDTH_DATA_LENGTH = 32
) ();
    logic [WIDTH_DATA_LENGTH-1:0] PC_F;
    logic                         Predicted;
    logic [WIDTH_DATA_LENGTH-1:0] PC_Pre;
    logic                         Update_Valid;
    logic [WIDTH_DATA_LENGTH-1:0] PC_E;
    logic [WIDTH_DATA_LENGTH-1:0] PC_ALU;
    logic                         Execute_E;
    logic [1:0]                   Result;
    logic                         Flush;
    logic [WIDTH_DATA_LENGTH-1:0] PC_Redirect;

    // Pipeline side: drives fetch PC and resolved-branch updates
    modport master (
        output PC_F, Update_Valid, PC_E, PC_ALU, Execute_E, Result,
        input  Predicted, PC_Pre, Flush, PC_Redirect
    );

    // Predictor side
    modport slave (
        input  PC_F, Update_Valid, PC_E, PC_ALU, Execute_E, Result,
        output Predicted, PC_Pre, Flush, PC_Redirect
    );
endinterface

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter next-state logic (no storage).
module bp_sat_counter
    import branch_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       up_i,
    output logic [1:0] ctr_o
);
    // Step toward taken or not-taken, holding at the strong states
    always_comb begin
        ctr_o = ctr_i;
        if (up_i && (ctr_i != CTR_STRONG_T)) begin
            ctr_o = ctr_i + 2'd1;
        end else if (!up_i && (ctr_i != CTR_STRONG_NT)) begin
            ctr_o = ctr_i - 2'd1;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup,
// execute-stage training, and same-cycle flush/redirect generation.
// Optional macro BRANCH_PRED_STATS_EN adds Branch_Count/Mispredict_Count.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int WIDTH_DATA_LENGTH = BP_WIDTH,
    parameter int BTB_ENTRIES       = BP_ENTRIES
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0]       Branch_Count,
    output logic [31:0]       Mispredict_Count
`endif
);
    localparam int W     = WIDTH_DATA_LENGTH;
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam logic [W-1:0] PC_STEP = W'(4);

    btb_entry_t btb_q [BTB_ENTRIES];
    btb_entry_t btb_d [BTB_ENTRIES];

    logic [IDX_W-1:0]   f_idx;
    logic [W-IDX_W-3:0] f_tag;
    btb_entry_t         f_entry;
    logic               f_hit;
    logic               f_pred;

    logic [IDX_W-1:0]   e_idx;
    logic [W-IDX_W-3:0] e_tag;
    btb_entry_t         e_entry;
    logic               e_hit;
    logic [1:0]         e_ctr_next;
    logic               upd_fire;

    // Fetch lookup straight from table state (no bypass of a same-cycle update)
    always_comb begin
        f_idx     = bp.PC_F[IDX_W+1:2];
        f_tag     = bp.PC_F[W-1:IDX_W+2];
        f_entry   = btb_q[f_idx];
        f_hit     = f_entry.valid && (f_entry.tag == f_tag);
        f_pred    = f_hit && f_entry.ctr[1];
        bp.Predicted = f_pred;
        bp.PC_Pre    = f_pred ? f_entry.target : (bp.PC_F + PC_STEP);
    end

    // Decode the resolved branch's slot; updates are ignored while in reset
    always_comb begin
        upd_fire = rst_n && bp.Update_Valid;
        e_idx    = bp.PC_E[IDX_W+1:2];
        e_tag    = bp.PC_E[W-1:IDX_W+2];
        e_entry  = btb_q[e_idx];
        e_hit    = e_entry.valid && (e_entry.tag == e_tag);
    end

    bp_sat_counter u_sat_counter (
        .ctr_i (e_entry.ctr),
        .up_i  (bp.Execute_E),
        .ctr_o (e_ctr_next)
    );

    // Flush on anything but a correct prediction; redirect target per result code
    always_comb begin
        bp.Flush = upd_fire && (bp.Result != RES_CORRECT);
        case (bp.Result)
            RES_WRONG_TARGET,
            RES_TAKE_ALU: bp.PC_Redirect = bp.PC_ALU;
            default:      bp.PC_Redirect = bp.PC_E + PC_STEP;
        endcase
    end

    // Table training: hit trains counter (and fixes target), taken miss allocates
    always_comb begin
        btb_d = btb_q;
        if (bp.Update_Valid) begin
            if (e_hit) begin
                btb_d[e_idx].ctr = e_ctr_next;
                if (bp.Result == RES_WRONG_TARGET) begin
                    btb_d[e_idx].target = bp.PC_ALU;
                end
            end else if (bp.Execute_E) begin
                btb_d[e_idx].valid  = 1'b1;
                btb_d[e_idx].tag    = e_tag;
                btb_d[e_idx].target = bp.PC_ALU;
                btb_d[e_idx].ctr    = CTR_WEAK_T;
            end
        end
    end

    // BTB storage; reset clears valids and parks counters at weak-not-taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_q[i].valid  <= 1'b0;
                btb_q[i].tag    <= '0;
                btb_q[i].target <= '0;
                btb_q[i].ctr    <= CTR_RESET;
            end
        end else begin
            btb_q <= btb_d;
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] branch_count_q;
    logic [31:0] branch_count_d;
    logic [31:0] mispredict_count_q;
    logic [31:0] mispredict_count_d;

    // Event counters, free-running with natural 2^32 wrap
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (bp.Update_Valid) begin
            branch_count_d = branch_count_q + 32'd1;
            if (bp.Result != RES_CORRECT) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign Branch_Count     = branch_count_q;
    assign Mispredict_Count = mispredict_count_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios plus a random phase
// checked against a behavioural BTB model through an expected-value queue.
module tb_branch_predictor;
    import branch_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] pc_f;
        logic         uv;
        logic [W-1:0] pc_e;
        logic [W-1:0] pc_alu;
        logic         ex;
        logic [1:0]   res;
        logic         pred;
        logic [W-1:0] pre;
        logic         fl;
        logic [W-1:0] rd;
    } step_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.WIDTH_DATA_LENGTH(W)) bp_if ();

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
`endif

    branch_predictor #(
        .WIDTH_DATA_LENGTH (W),
        .BTB_ENTRIES       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if.slave)
`ifdef BRANCH_PRED_STATS_EN
        ,
        .Branch_Count     (branch_count),
        .Mispredict_Count (mispredict_count)
`endif
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [2*W+1:0] exp_q[$];

    // Observation vector; redirect only matters while flushing
    function automatic logic [2*W+1:0] obs_pack(input logic p, input logic [W-1:0] pre,
                                                input logic f, input logic [W-1:0] r);
        return {p, pre, f, (f ? r : {W{1'b0}})};
    endfunction

    function automatic step_t mk(input logic [W-1:0] pc_f, input logic uv, input logic [W-1:0] pc_e,
                                 input logic [W-1:0] pc_alu, input logic ex, input logic [1:0] res,
                                 input logic pred, input logic [W-1:0] pre, input logic fl,
                                 input logic [W-1:0] rd);
        step_t s;
        s.pc_f = pc_f; s.uv = uv; s.pc_e = pc_e; s.pc_alu = pc_alu; s.ex = ex; s.res = res;
        s.pred = pred; s.pre = pre; s.fl = fl; s.rd = rd;
        return s;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [W-1:0] pc_f, input logic uv, input logic [W-1:0] pc_e,
                         input logic [W-1:0] pc_alu, input logic ex, input logic [1:0] res);
        bp_if.PC_F         = pc_f;
        bp_if.Update_Valid = uv;
        bp_if.PC_E         = pc_e;
        bp_if.PC_ALU       = pc_alu;
        bp_if.Execute_E    = ex;
        bp_if.Result       = res;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [2*W+1:0] got, exp;
        drive(32'h100, 1'b1, 32'h100, 32'h200, 1'b1, RES_TAKE_ALU);
        #2 rst_n = 1'b0;
        // Update inputs active during reset: no flush, table stays empty
        exp_q.push_back(obs_pack(1'b0, 32'h104, 1'b0, 32'h0));
        @(negedge clk);
        got = obs_pack(bp_if.Predicted, bp_if.PC_Pre, bp_if.Flush, bp_if.PC_Redirect);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_in_reset: got %h expected %h", got, exp);
        end
        @(posedge clk); #1;
        drive(32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0, RES_CORRECT);
        exp_q.push_back(obs_pack(1'b0, 32'h0, 1'b0, 32'h0));
        @(negedge clk);
        got = obs_pack(bp_if.Predicted, bp_if.PC_Pre, bp_if.Flush, bp_if.PC_Redirect);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_pc_wrap: got %h expected %h", got, exp);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, RES_CORRECT);
        exp_q.push_back(obs_pack(1'b0, 32'h104, 1'b0, 32'h0));
        @(negedge clk);
        got = obs_pack(bp_if.Predicted, bp_if.PC_Pre, bp_if.Flush, bp_if.PC_Redirect);
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_miss: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_allocate_hit();
        step_t s[$];
        logic [2*W+1:0] got, exp;
        s.push_back(mk(32'h100, 1, 32'h100, 32'h200, 1, RES_TAKE_ALU, 0, 32'h104, 1, 32'h200));
        s.push_back(mk(32'h100, 0, 32'h0,   32'h0,   0, RES_CORRECT,  1, 32'h200, 0, 32'h0));
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i].pc_f, s[i].uv, s[i].pc_e, s[i].pc_alu, s[i].ex, s[i].res);
            exp_q.push_back(obs_pack(s[i].pred, s[i].pre, s[i].fl, s[i].rd));
            @(negedge clk);
            got = obs_pack(bp_if.Predicted, bp_if.PC_Pre, bp_if.Flush, bp_if.PC_Redirect);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL allocate_hit step %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_saturation();
        step_t s[$];
        logic [2*W+1:0] got, exp;
        // ctr 10 -> 01 -> 00 -> 00, then up 01 -> 10 -> 11 -> 11, down to 10
        s.push_back(mk(32'h100, 1, 32'h100, 32'h200, 0, RES_RET_PC4,  1, 32'h200, 1, 32'h104));
        s.push_back(mk(32'h100, 1, 32'h100, 32'h200, 0, RES_CORRECT,  0, 32'h104, 0, 32'h0));
        s.push_back(mk(32'h100, 1, 32'h100, 32'h200, 0, RES_CORRECT,  0, 32'h104, 0, 32'h0));
        s.push_back(mk(32'h100, 1, 32'h100, 32'h200, 1, RES_TAKE_ALU, 0, 32'h104, 1, 32'h200));
        s.push_back(mk(32'h100, 0, 32'h0,   32'h0,   0, RES_CORRECT,  0, 32'h104, 0, 32'h0));
        s.push_back(mk(32'h100, 1, 32'h100, 32'h200, 1, RES_TAKE_ALU, 0, 32'h104, 1, 32'h200));
        s.push_back(mk(32'h100, 0, 32'h0,   32'h0,   0, RES_CORRECT,  1, 32'h200, 0, 32'h0));
        s.push_back(mk(32'h100, 1, 32'h100, 32'h200, 1, RES_CORRECT,  1, 32'h200, 0, 32'h0));
        s.push_back(mk(32'h100, 1, 32'h100, 32'h200, 1, RES_CORRECT,  1, 32'h200, 0, 32'h0));
        s.push_back(mk(32'h100, 1, 32'h100, 32'h200, 0, RES_RET_PC4,  1, 32'h200, 1, 32'h104));
        s.push_back(mk(32'h100, 0, 32'h0,   32'h0,   0, RES_CORRECT,  1, 32'h200, 0, 32'h0));
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i].pc_f, s[i].uv, s[i].pc_e, s[i].pc_alu, s[i].ex, s[i].res);
            exp_q.push_back(obs_pack(s[i].pred, s[i].pre, s[i].fl, s[i].rd));
            @(negedge clk);
            got = obs_pack(bp_if.Predicted, bp_if.PC_Pre, bp_if.Flush, bp_if.PC_Redirect);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL saturation step %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_wrong_target();
        step_t s[$];
        logic [2*W+1:0] got, exp;
        s.push_back(mk(32'h100, 1, 32'h100, 32'h300, 1, RES_WRONG_TARGET, 1, 32'h200, 1, 32'h300));
        s.push_back(mk(32'h100, 0, 32'h0,   32'h0,   0, RES_CORRECT,      1, 32'h300, 0, 32'h0));
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i].pc_f, s[i].uv, s[i].pc_e, s[i].pc_alu, s[i].ex, s[i].res);
            exp_q.push_back(obs_pack(s[i].pred, s[i].pre, s[i].fl, s[i].rd));
            @(negedge clk);
            got = obs_pack(bp_if.Predicted, bp_if.PC_Pre, bp_if.Flush, bp_if.PC_Redirect);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL wrong_target step %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_alias_collision();
        step_t s[$];
        logic [2*W+1:0] got, exp;
        // 0x100, 0x140, 0x180 share index 0 with different tags
        s.push_back(mk(32'h100, 1, 32'h140, 32'h500, 1, RES_TAKE_ALU, 1, 32'h300, 1, 32'h500));
        s.push_back(mk(32'h100, 0, 32'h0,   32'h0,   0, RES_CORRECT,  0, 32'h104, 0, 32'h0));
        s.push_back(mk(32'h140, 1, 32'h180, 32'h700, 0, RES_CORRECT,  1, 32'h500, 0, 32'h0));
        s.push_back(mk(32'h140, 0, 32'h0,   32'h0,   0, RES_CORRECT,  1, 32'h500, 0, 32'h0));
        s.push_back(mk(32'h180, 0, 32'h0,   32'h0,   0, RES_CORRECT,  0, 32'h184, 0, 32'h0));
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i].pc_f, s[i].uv, s[i].pc_e, s[i].pc_alu, s[i].ex, s[i].res);
            exp_q.push_back(obs_pack(s[i].pred, s[i].pre, s[i].fl, s[i].rd));
            @(negedge clk);
            got = obs_pack(bp_if.Predicted, bp_if.PC_Pre, bp_if.Flush, bp_if.PC_Redirect);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL alias_collision step %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        logic [2*W+1:0] got, exp;
        s.push_back(mk(32'h204, 1, 32'h204, 32'h800, 1, RES_TAKE_ALU,     0, 32'h208, 1, 32'h800));
        s.push_back(mk(32'h204, 1, 32'h208, 32'h900, 1, RES_TAKE_ALU,     1, 32'h800, 1, 32'h900));
        s.push_back(mk(32'h208, 1, 32'h204, 32'hA00, 1, RES_WRONG_TARGET, 1, 32'h900, 1, 32'hA00));
        s.push_back(mk(32'h204, 0, 32'h0,   32'h0,   0, RES_CORRECT,      1, 32'hA00, 0, 32'h0));
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i].pc_f, s[i].uv, s[i].pc_e, s[i].pc_alu, s[i].ex, s[i].res);
            exp_q.push_back(obs_pack(s[i].pred, s[i].pre, s[i].fl, s[i].rd));
            @(negedge clk);
            got = obs_pack(bp_if.Predicted, bp_if.PC_Pre, bp_if.Flush, bp_if.PC_Redirect);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_mid_update_reset();
        step_t s[$];
        logic [2*W+1:0] got, exp;
        @(posedge clk); #1;
        drive(32'h100, 1'b1, 32'h240, 32'h600, 1'b1, RES_TAKE_ALU);
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, RES_CORRECT);
        @(negedge clk);
`ifdef BRANCH_PRED_STATS_EN
        n_checks++;
        if ((branch_count !== 32'd0) || (mispredict_count !== 32'd0)) begin
            n_fail++;
            $display("FAIL mid_reset_stats: got %0d/%0d expected 0/0", branch_count, mispredict_count);
        end
`endif
        s.push_back(mk(32'h100, 0, 32'h0,   32'h0,   0, RES_CORRECT,  0, 32'h104, 0, 32'h0));
        s.push_back(mk(32'h140, 0, 32'h0,   32'h0,   0, RES_CORRECT,  0, 32'h144, 0, 32'h0));
        s.push_back(mk(32'h204, 0, 32'h0,   32'h0,   0, RES_CORRECT,  0, 32'h208, 0, 32'h0));
        s.push_back(mk(32'h240, 1, 32'h240, 32'h600, 1, RES_TAKE_ALU, 0, 32'h244, 1, 32'h600));
        s.push_back(mk(32'h240, 0, 32'h0,   32'h0,   0, RES_CORRECT,  1, 32'h600, 0, 32'h0));
        foreach (s[i]) begin
            @(posedge clk); #1;
            drive(s[i].pc_f, s[i].uv, s[i].pc_e, s[i].pc_alu, s[i].ex, s[i].res);
            exp_q.push_back(obs_pack(s[i].pred, s[i].pre, s[i].fl, s[i].rd));
            @(negedge clk);
            got = obs_pack(bp_if.Predicted, bp_if.PC_Pre, bp_if.Flush, bp_if.PC_Redirect);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mid_update_reset step %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_random();
        logic         m_valid  [16];
        logic [25:0]  m_tag    [16];
        logic [W-1:0] m_target [16];
        logic [1:0]   m_ctr    [16];
        logic [31:0]  m_branches, m_misp;
        logic [W-1:0] pc_f, pc_e, alu, pre, rd;
        logic         uv, ex, pred, fl, hit;
        logic [1:0]   res;
        logic [3:0]   idx;
        logic [2*W+1:0] got, exp;
        @(posedge clk); #1;
        drive(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, RES_CORRECT);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 2'b01;
        end
        m_branches = 0;
        m_misp     = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            pc_f = 32'h1000 + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 2)) << 6);
            pc_e = 32'h1000 + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 2)) << 6);
            alu  = $urandom() & 32'hFFFF_FFFC;
            uv   = ($urandom_range(0, 3) != 0);
            ex   = $urandom_range(0, 1) == 1;
            res  = 2'($urandom_range(0, 3));
            drive(pc_f, uv, pc_e, alu, ex, res);
            idx  = pc_f[5:2];
            pred = m_valid[idx] && (m_tag[idx] == pc_f[31:6]) && m_ctr[idx][1];
            pre  = pred ? m_target[idx] : pc_f + 32'd4;
            fl   = uv && (res != 2'b01);
            rd   = ((res == 2'b00) || (res == 2'b11)) ? alu : pc_e + 32'd4;
            exp_q.push_back(obs_pack(pred, pre, fl, rd));
            @(negedge clk);
            got = obs_pack(bp_if.Predicted, bp_if.PC_Pre, bp_if.Flush, bp_if.PC_Redirect);
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", n, got, exp);
            end
            if (uv) begin
                m_branches = m_branches + 1;
                if (res != 2'b01) m_misp = m_misp + 1;
                idx = pc_e[5:2];
                hit = m_valid[idx] && (m_tag[idx] == pc_e[31:6]);
                if (hit) begin
                    if (ex && m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'd1;
                    else if (!ex && m_ctr[idx] != 2'b00) m_ctr[idx] = m_ctr[idx] - 2'd1;
                    if (res == 2'b00) m_target[idx] = alu;
                end else if (ex) begin
                    m_valid[idx] = 1'b1; m_tag[idx] = pc_e[31:6];
                    m_target[idx] = alu; m_ctr[idx] = 2'b10;
                end
            end
        end
        @(posedge clk); #1;
        drive(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, RES_CORRECT);
        @(negedge clk);
`ifdef BRANCH_PRED_STATS_EN
        n_checks++;
        if ((branch_count !== m_branches) || (mispredict_count !== m_misp)) begin
            n_fail++;
            $display("FAIL random_stats: got %0d/%0d expected %0d/%0d",
                     branch_count, mispredict_count, m_branches, m_misp);
        end
`else
        if (m_branches < m_misp) $display("random phase: counter model inconsistent");
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, RES_CORRECT);
        test_reset();
        test_allocate_hit();
        test_saturation();
        test_wrong_target();
        test_alias_collision();
        test_back_to_back();
        test_mid_update_reset();
        test_random();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
